ws_array_feeder: RTL and testbench
==================================

// Module: ws_array_feeder
// PURPOSE
//  Job sequencer and operand feeder that sits directly upstream of the weight-stationary PE grid.
//  Weights:
//   - Accepts N_ROWS weight vectors over a valid/ready stream.
//   - Drives per-column b_out and a one-hot per-row load_weight.
//  Activations:
//   - Streams k_len activation vectors onto the grid's left edge.
//   - Generates column-skewed en/clr so PE(r,c) gates its MAC c cycles after column 0.
//  Guarantees a PE never sees load_weight and en in the same cycle.
// PARAMETERS
//  N_ROWS  4   PE rows; one weight vector per row, one activation lane per row
//  N_COLS  4   PE columns; weight lanes per vector, length of en/clr skew chain
//  KW      16  width of k_len (activation beats per job)
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           asynchronous active-low reset
//  start        in   1           job request; sampled in IDLE only
//  k_len        in   KW          activation beats for the job; sampled with start
//  w_valid      in   1           weight beat valid
//  w_ready      out  1           weight beat ready
//  w_data       in   N_COLS*8    signed int8 weights; lane c -> column c
//  a_valid      in   1           activation beat valid
//  a_ready      out  1           activation beat ready
//  a_data       in   N_ROWS*8    signed int8 activations; lane r -> row r
//  b_out        out  N_COLS*8    weight bus to grid columns
//  load_weight  out  N_ROWS      one-hot row weight-load strobe
//  a_out        out  N_ROWS*8    activation to column 0 of each row
//  en_col       out  N_COLS      MAC enable per column (skewed)
//  clr_col      out  N_COLS      accumulator clear per column (skewed)
//  busy         out  1           state != IDLE
//  done         out  1           one-cycle job-complete pulse
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; counters=0; skew chain=0.
//    All outputs 0 (w_ready, a_ready, b_out, load_weight, a_out, en_col, clr_col, busy, done).
//  - FSM: IDLE -> LOAD -> CLR -> STREAM -> FLUSH -> IDLE. busy=1 outside IDLE.
//  IDLE:
//   - start=1 and k_len!=0: latch k_len, go to LOAD.
//   - start with k_len==0: ignored.
//   - start outside IDLE: ignored.
//  LOAD:
//   - w_ready=1 (combinational from state).
//   - Beat i (i = 0..N_ROWS-1) handshakes on w_valid&w_ready.
//   - Next cycle: b_out=w_data and load_weight=1<<i, both registered.
//   - Otherwise load_weight=0; b_out holds.
//   - After beat N_ROWS-1 go to CLR.
//  CLR:
//   - Exactly one cycle; w_ready=a_ready=0.
//   - Next cycle: clr_col[0]=1.
//   - This cycle separates the last load_weight from the first en.
//  STREAM:
//   - a_ready=1.
//   - On handshake, next cycle: a_out=a_data and en_col[0]=1.
//   - Without a handshake, next cycle: a_out=0 and en_col[0]=0 (bubble, no accumulate).
//   - Beat counter counts to latched k_len, then go to FLUSH.
//  Skew:
//   - en_col[c] = en_col[c-1] delayed one cycle; same rule for clr_col.
//   - Shift every cycle in every non-reset state.
//  FLUSH:
//   - Lasts N_COLS cycles, so the last beat's en has reached column N_COLS-1 and been consumed.
//   - Then done=1 for 1 cycle concurrent with return to IDLE; busy=0 that same cycle.
//  Invariants:
//   - load_weight!=0 never coincides with any en_col/clr_col bit.
//   - popcount(load_weight)<=1.
//   - en_col[0] pulses per job == k_len.
//  Counters:
//   - Row counter width clog2(N_ROWS).
//   - Beat counter KW bits; k_len = 2^KW-1 must not wrap.
//  Latency, all job-level counts taken from the cycle start is accepted:
//   - First load_weight = LOAD-entry cycle + 1 (with w_valid held high).
//   - done = N_ROWS + 1 + k_len + N_COLS + 1 cycles after start, with no stalls.
// TESTING
//  1. N=4, start with k_len=3, continuous valids:
//     - load_weight = 0001,0010,0100,1000 on consecutive cycles.
//     - clr_col = 0001 then 0010 ... 1000.
//     - en_col[0] high 3 cycles; en_col[3] lags it by 3.
//     - done 13 cycles after start.
//  2. w_valid gap of 2 cycles between beats 1 and 2:
//     - load_weight holds 0 during the gap; b_out is unchanged.
//     - Row order is preserved.
//  3. a_valid toggling 1,0,1,0,1 with k_len=3:
//     - a_out = a,0,a,0,a; en_col[0] = 1,0,1,0,1.
//     - Exactly 3 beats accepted, then FLUSH.
//  4. start with k_len=0, and start asserted while busy:
//     - No state change, no ready, no done.
//  5. rst_n low mid-STREAM:
//     - All outputs 0 immediately (async).
//     - After release: IDLE; a new job runs like scenario 1.
//  6. Assertion run over scenarios 1-5:
//     - load_weight & |en_col never both nonzero.
//     - load_weight is one-hot or 0.

Source files
------------

// File: rtl/ws_array_feeder.sv
// Job sequencer and operand feeder for a weight-stationary PE grid.
// A job loads one weight vector per PE row, spends one cycle that clears the
// accumulators, streams k_len activation beats on the left edge of the grid,
// then flushes for N_COLS cycles while the column-skewed enables drain.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start with a non-zero k_len
//   LOAD   | accepting N_ROWS weight beats; one row strobe per beat
//   CLR    | single gap cycle; launches clr into column 0
//   STREAM | accepting k_len activation beats; bubbles carry no enable
//   FLUSH  | N_COLS cycles for the last enable to reach the last column
module ws_array_feeder #(
    parameter int N_ROWS = 4,
    parameter int N_COLS = 4,
    parameter int KW     = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                start_i,
    input  logic [KW-1:0]       k_len_i,
    input  logic                w_valid_i,
    output logic                w_ready_o,
    input  logic [N_COLS*8-1:0] w_data_i,
    input  logic                a_valid_i,
    output logic                a_ready_o,
    input  logic [N_ROWS*8-1:0] a_data_i,
    output logic [N_COLS*8-1:0] b_out_o,
    output logic [N_ROWS-1:0]   load_weight_o,
    output logic [N_ROWS*8-1:0] a_out_o,
    output logic [N_COLS-1:0]   en_col_o,
    output logic [N_COLS-1:0]   clr_col_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int FW = $clog2(N_COLS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CLR,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       row_q, row_d;
    logic [KW-1:0]       beat_q, beat_d;
    logic [FW-1:0]       flush_q, flush_d;
    logic [N_COLS*8-1:0] b_q, b_d;
    logic [N_ROWS-1:0]   lw_q, lw_d;
    logic [N_ROWS*8-1:0] a_q, a_d;
    logic [N_COLS-1:0]   en_q, en_d;
    logic [N_COLS-1:0]   clr_q, clr_d;
    logic                done_q, done_d;
    logic                en0, clr0;

    assign w_ready_o     = (state_q == S_LOAD);
    assign a_ready_o     = (state_q == S_STREAM);
    assign busy_o        = (state_q != S_IDLE);
    assign b_out_o       = b_q;
    assign load_weight_o = lw_q;
    assign a_out_o       = a_q;
    assign en_col_o      = en_q;
    assign clr_col_o     = clr_q;
    assign done_o        = done_q;

    // Next state, counters and registered grid outputs.
    // The beat counter counts down from the latched k_len, so a k_len of
    // all ones never needs a wider compare and cannot wrap.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        b_d     = b_q;
        lw_d    = '0;
        a_d     = '0;
        en0     = 1'b0;
        clr0    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && (k_len_i != '0)) begin
                    beat_d  = k_len_i;
                    row_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_valid_i) begin
                    b_d  = w_data_i;
                    lw_d = N_ROWS'(1) << row_q;
                    if (row_q == RW'(N_ROWS - 1)) begin
                        state_d = S_CLR;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            S_CLR: begin
                clr0    = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (a_valid_i) begin
                    a_d = a_data_i;
                    en0 = 1'b1;
                    if (beat_q == KW'(1)) begin
                        flush_d = FW'(N_COLS - 1);
                        state_d = S_FLUSH;
                    end else begin
                        beat_d = beat_q - KW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (flush_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    flush_d = flush_q - FW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        en_d  = {en_q[N_COLS-2:0], en0};
        clr_d = {clr_q[N_COLS-2:0], clr0};
    end

    // State, counter and output registers; everything clears on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            b_q     <= '0;
            lw_q    <= '0;
            a_q     <= '0;
            en_q    <= '0;
            clr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            b_q     <= b_d;
            lw_q    <= lw_d;
            a_q     <= a_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ws_array_feeder.sv
// Directed bench for ws_array_feeder. Cycle index k counts rising edges after
// the edge at which start was first presented (k=0 is the accept cycle).
module tb_ws_array_feeder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] k_len;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic [31:0] b_out;
    logic [3:0]  load_weight;
    logic [31:0] a_out;
    logic [3:0]  en_col;
    logic [3:0]  clr_col;
    logic        busy;
    logic        done;

    int vecs = 0;
    int errs = 0;

    logic [31:0] W [4];
    logic [31:0] A [3];

    ws_array_feeder #(.N_ROWS(4), .N_COLS(4), .KW(16)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .k_len_i       (k_len),
        .w_valid_i     (w_valid),
        .w_ready_o     (w_ready),
        .w_data_i      (w_data),
        .a_valid_i     (a_valid),
        .a_ready_o     (a_ready),
        .a_data_i      (a_data),
        .b_out_o       (b_out),
        .load_weight_o (load_weight),
        .a_out_o       (a_out),
        .en_col_o      (en_col),
        .clr_col_o     (clr_col),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grid-safety invariants, checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n) begin
            vecs++;
            assert (!((load_weight != 4'b0) && ((en_col | clr_col) != 4'b0))) else begin
                errs++;
                $error("FAIL lw_vs_en observed lw=%b en=%b clr=%b expected no overlap", load_weight, en_col, clr_col);
            end
            vecs++;
            assert ($onehot0(load_weight)) else begin
                errs++;
                $error("FAIL lw_onehot observed=%b expected one-hot or zero", load_weight);
            end
        end
    end

    task automatic idle_inputs();
        start = 0; k_len = 0; w_valid = 0; a_valid = 0; w_data = 0; a_data = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_a_ready"}, a_ready, 0);
        chk({tag, "_b_out"}, b_out, 0);
        chk({tag, "_lw"}, load_weight, 0);
        chk({tag, "_a_out"}, a_out, 0);
        chk({tag, "_en"}, en_col, 0);
        chk({tag, "_clr"}, clr_col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Nominal job, k_len=3, all valids held high. Stops after cycle stop_k
    // when stop_k is non-zero.
    task automatic run_basic(input string tag, input int stop_k);
        logic [3:0]  exp_lw, exp_en, exp_clr;
        logic [31:0] exp_a;
        int en0_cnt;
        en0_cnt = 0;
        start = 1; k_len = 3; w_valid = 1; w_data = W[0]; a_valid = 1; a_data = A[0];
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_lw  = (k >= 2 && k <= 5) ? (4'b0001 << (k - 2)) : 4'b0;
            exp_clr = (k >= 6 && k <= 9) ? (4'b0001 << (k - 6)) : 4'b0;
            exp_en  = 4'b0;
            for (int c = 0; c < 4; c++)
                if (k >= 7 + c && k <= 9 + c) exp_en[c] = 1'b1;
            exp_a = (k >= 7 && k <= 9) ? A[k - 7] : 32'h0;
            chk({tag, "_lw"}, load_weight, exp_lw);
            chk({tag, "_clr"}, clr_col, exp_clr);
            chk({tag, "_en"}, en_col, exp_en);
            chk({tag, "_a_out"}, a_out, exp_a);
            chk({tag, "_done"}, done, k == 13);
            chk({tag, "_busy"}, busy, k <= 12);
            chk({tag, "_w_ready"}, w_ready, k >= 1 && k <= 4);
            chk({tag, "_a_ready"}, a_ready, k >= 6 && k <= 8);
            if (k >= 2 && k <= 5) chk({tag, "_b_out"}, b_out, W[k - 2]);
            if (en_col[0]) en0_cnt++;
            if (k == stop_k) return;
            start = 0;
            if (k <= 4) w_data = W[k - 1];
            if (k >= 6 && k <= 8) a_data = A[k - 6];
            if (k >= 9) begin w_valid = 0; a_valid = 0; end
        end
        chk({tag, "_en0_pulses"}, en0_cnt, 3);
        idle_inputs();
    endtask

    initial begin
        logic [3:0] exp_lw;
        logic [3:0] exp_en;
        logic [31:0] exp_a;
        int pulses;
        int wsel [7];

        W[0] = 32'h0102_0304; W[1] = 32'h80FF_7F11; W[2] = 32'hA5A5_5A5A; W[3] = 32'hDEAD_BEEF;
        A[0] = 32'h1122_3344; A[1] = 32'h8899_AABB; A[2] = 32'hF00D_CAFE;

        // Reset state
        idle_inputs();
        rst_n = 0;
        #1;
        check_all_zero("reset");
        #11 rst_n = 1;
        tick();
        check_all_zero("post_reset");

        // Scenario 1: nominal job
        run_basic("s1", 0);
        tick();

        // Scenario 2: two-cycle w_valid gap between beats 1 and 2
        wsel = '{0, 0, 1, 2, 2, 2, 3};
        start = 1; k_len = 3; w_valid = 1; w_data = W[0]; a_valid = 1; a_data = A[0];
        for (int k = 1; k <= 16; k++) begin
            tick();
            case (k)
                2: exp_lw = 4'b0001;
                3: exp_lw = 4'b0010;
                6: exp_lw = 4'b0100;
                7: exp_lw = 4'b1000;
                default: exp_lw = 4'b0000;
            endcase
            chk("s2_lw", load_weight, exp_lw);
            case (k)
                2: chk("s2_b_out", b_out, W[0]);
                3, 4, 5: chk("s2_b_out_hold", b_out, W[1]);
                6: chk("s2_b_out", b_out, W[2]);
                7: chk("s2_b_out", b_out, W[3]);
                default: ;
            endcase
            chk("s2_done", done, k == 15);
            start = 0;
            w_valid = !(k == 3 || k == 4);
            if (k <= 6) w_data = W[wsel[k]];
        end
        idle_inputs();
        tick();

        // Scenario 3: a_valid 1,0,1,0,1
        start = 1; k_len = 3; w_valid = 1; w_data = W[0]; a_valid = 0; a_data = 0;
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_en = 4'b0;
            for (int c = 0; c < 4; c++)
                if ((k - c == 7) || (k - c == 9) || (k - c == 11)) exp_en[c] = 1'b1;
            case (k)
                7: exp_a = A[0];
                9: exp_a = A[1];
                11: exp_a = A[2];
                default: exp_a = 32'h0;
            endcase
            chk("s3_en", en_col, exp_en);
            chk("s3_a_out", a_out, exp_a);
            chk("s3_a_ready", a_ready, k >= 6 && k <= 10);
            chk("s3_done", done, k == 15);
            if (en_col[0]) pulses++;
            start = 0;
            if (k <= 4) w_data = W[k - 1];
            if (k >= 6 && k <= 10 && ((k - 6) % 2 == 0)) begin
                a_valid = 1; a_data = A[(k - 6) / 2];
            end else begin
                a_valid = 0; a_data = 32'hFFFF_FFFF;
            end
        end
        chk("s3_beats", pulses, 3);
        idle_inputs();
        tick();

        // Scenario 4a: start with k_len=0 is ignored
        start = 1; k_len = 0; w_valid = 1; a_valid = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("s4_zero_busy", busy, 0);
            chk("s4_zero_w_ready", w_ready, 0);
            chk("s4_zero_done", done, 0);
        end
        // Scenario 4b: start held with k_len=5 while a k_len=1 job runs
        k_len = 1;
        pulses = 0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            k_len = 5;
            if (k >= 9) start = 0;
            chk("s4_busy", busy, k <= 10);
            chk("s4_done", done, k == 11);
            if (en_col[0]) pulses++;
        end
        chk("s4_beats", pulses, 1);
        idle_inputs();
        tick();

        // Scenario 5: async reset mid-STREAM, then a fresh nominal job
        run_basic("s5_pre", 7);
        #2 rst_n = 0;
        #1;
        check_all_zero("s5_async");
        tick();
        idle_inputs();
        #2 rst_n = 1;
        tick();
        check_all_zero("s5_idle");
        run_basic("s5_post", 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
